// File: rtl/press_classifier_if.sv
// Strobe bundle between the edge detectors, the gesture classifier and control logic.
// The master drives the press/release strobes; the slave returns the classified events.
interface press_classifier_if;
    logic i_press;
    logic i_release;
    logic o_short;
    logic o_long;
    logic o_double;
    logic o_busy;

    modport master (
        output i_press, i_release,
        input  o_short, o_long, o_double, o_busy
    );

    modport slave (
        input  i_press, i_release,
        output o_short, o_long, o_double, o_busy
    );
endinterface

// File: rtl/press_classifier.sv
// Classifies debounced button press/release strobes into short, long and double events.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  IDLE     | no gesture in progress
//  HELD     | button down, timing toward a long press
//  GAP      | released after a short hold, waiting for a second press
//  WAIT_REL | gesture already decided, waiting for the button to come up
module press_classifier #(
    parameter int LONG_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 12500000,
    parameter int CNT_W       = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    press_classifier_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_GAP,
        S_WAIT_REL
    } state_t;

    localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_short, r_long, r_double;
    logic             w_short, w_long, w_double;
    logic             w_press, w_release;

    // Simultaneous press and release is a protocol violation: drop both.
    assign w_press   = bus.i_press & ~bus.i_release;
    assign w_release = bus.i_release & ~bus.i_press;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_short  <= w_short;
            r_long   <= w_long;
            r_double <= w_double;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_short     = 1'b0;
        w_long      = 1'b0;
        w_double    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                end
            end
            S_HELD: begin
                // A release on the terminal edge still counts as short.
                if (w_release) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LONG_TC) begin
                    w_long      = 1'b1;
                    w_state_nxt = S_WAIT_REL;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (w_press) begin
                    w_double    = 1'b1;
                    w_state_nxt = S_WAIT_REL;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == GAP_TC) begin
                    w_short     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            S_WAIT_REL: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.o_short  = r_short;
    assign bus.o_long   = r_long;
    assign bus.o_double = r_double;
    assign bus.o_busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with a deadline-based gesture model and per-cycle compare.
module tb_press_classifier;
    localparam int L = 8;
    localparam int G = 5;
    localparam int W = 4;

    localparam int M_IDLE = 0;
    localparam int M_HELD = 1;
    localparam int M_GAP  = 2;
    localparam int M_WAIT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_checks = 0;
    int   rel = 0;

    press_classifier_if bus ();

    press_classifier #(.LONG_CYCLES(L), .GAP_CYCLES(G), .CNT_W(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Gesture model: tracks the phase of the gesture and the absolute edge at which
    // the pending decision falls due, rather than a running counter.
    int   m_mode = M_IDLE;
    int   m_edge = 0;
    int   m_deadline = 0;
    logic exp_short = 1'b0, exp_long = 1'b0, exp_double = 1'b0, exp_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode     <= M_IDLE;
            exp_short  <= 1'b0;
            exp_long   <= 1'b0;
            exp_double <= 1'b0;
            exp_busy   <= 1'b0;
        end else begin : model_step
            int  e, mode, dl;
            bit  p, r, s, lg, d;
            e    = m_edge + 1;
            mode = m_mode;
            dl   = m_deadline;
            p    = bus.i_press && !bus.i_release;
            r    = bus.i_release && !bus.i_press;
            s    = 1'b0;
            lg   = 1'b0;
            d    = 1'b0;
            if (mode == M_IDLE) begin
                if (p) begin mode = M_HELD; dl = e + L; end
            end else if (mode == M_HELD) begin
                if (r) begin mode = M_GAP; dl = e + G; end
                else if (e == dl) begin lg = 1'b1; mode = M_WAIT; end
            end else if (mode == M_GAP) begin
                if (p) begin d = 1'b1; mode = M_WAIT; end
                else if (e == dl) begin s = 1'b1; mode = M_IDLE; end
            end else begin
                if (r) mode = M_IDLE;
            end
            m_edge     <= e;
            m_mode     <= mode;
            m_deadline <= dl;
            exp_short  <= s;
            exp_long   <= lg;
            exp_double <= d;
            exp_busy   <= (mode != M_IDLE);
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at rel edge %0d: got %b, expected %b", name, rel, act, exp);
    endtask

    always @(negedge clk) begin
        chk("model_short",  bus.o_short,  exp_short);
        chk("model_long",   bus.o_long,   exp_long);
        chk("model_double", bus.o_double, exp_double);
        chk("model_busy",   bus.o_busy,   exp_busy);
    end

    // Advance to 1 ns after relative edge n.
    task automatic goto(input int n);
        if (rel < n) begin
            while (rel < n) begin
                @(posedge clk);
                rel++;
            end
            #1;
        end
    endtask

    // Present a strobe so that it is sampled at relative edge n.
    task automatic pulse(input int n, input logic p, input logic r);
        goto(n - 1);
        bus.i_press   = p;
        bus.i_release = r;
        goto(n);
        bus.i_press   = 1'b0;
        bus.i_release = 1'b0;
    endtask

    task automatic do_reset();
        bus.i_press   = 1'b0;
        bus.i_release = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_short",  bus.o_short,  1'b0);
        chk("rst_long",   bus.o_long,   1'b0);
        chk("rst_double", bus.o_double, 1'b0);
        chk("rst_busy",   bus.o_busy,   1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel = 0;
    endtask

    initial begin
        bus.i_press   = 1'b0;
        bus.i_release = 1'b0;

        // Short press
        do_reset();
        pulse(10, 1'b1, 1'b0);
        pulse(13, 1'b0, 1'b1);
        goto(17);
        chk("short_pre",      bus.o_short, 1'b0);
        chk("short_busy_pre", bus.o_busy,  1'b1);
        goto(18);
        chk("short_fire",     bus.o_short, 1'b1);
        chk("short_busy_end", bus.o_busy,  1'b0);
        goto(19);
        chk("short_once",     bus.o_short, 1'b0);
        goto(25);

        // Long press, released at 30
        do_reset();
        pulse(10, 1'b1, 1'b0);
        goto(17);
        chk("long_pre",  bus.o_long, 1'b0);
        goto(18);
        chk("long_fire", bus.o_long, 1'b1);
        goto(19);
        chk("long_once", bus.o_long, 1'b0);
        pulse(30, 1'b0, 1'b1);
        chk("long_busy_fall", bus.o_busy,  1'b0);
        goto(31);
        chk("long_rel_quiet", bus.o_short, 1'b0);
        goto(34);

        // Release exactly on the long terminal edge: short wins
        do_reset();
        pulse(10, 1'b1, 1'b0);
        pulse(18, 1'b0, 1'b1);
        chk("bound18_nolong", bus.o_long,  1'b0);
        goto(23);
        chk("bound18_short",  bus.o_short, 1'b1);
        goto(26);

        // Release one edge late: long
        do_reset();
        pulse(10, 1'b1, 1'b0);
        goto(18);
        chk("bound19_long", bus.o_long, 1'b1);
        pulse(19, 1'b0, 1'b1);
        chk("bound19_once", bus.o_long, 1'b0);
        goto(22);

        // Double press on the last valid edge
        do_reset();
        pulse(10, 1'b1, 1'b0);
        pulse(13, 1'b0, 1'b1);
        pulse(18, 1'b1, 1'b0);
        chk("double_fire",  bus.o_double, 1'b1);
        chk("double_noshort", bus.o_short, 1'b0);
        pulse(21, 1'b0, 1'b1);
        chk("double_idle",  bus.o_busy,   1'b0);
        goto(24);

        // Second press one edge late: short decided first
        do_reset();
        pulse(10, 1'b1, 1'b0);
        pulse(13, 1'b0, 1'b1);
        goto(18);
        chk("late2_short",    bus.o_short,  1'b1);
        pulse(19, 1'b1, 1'b0);
        chk("late2_nodouble", bus.o_double, 1'b0);
        pulse(22, 1'b0, 1'b1);
        goto(30);

        // Async reset mid-HELD
        do_reset();
        pulse(10, 1'b1, 1'b0);
        goto(15);
        chk("areset_busy_pre", bus.o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_busy",   bus.o_busy,   1'b0);
        chk("areset_short",  bus.o_short,  1'b0);
        chk("areset_long",   bus.o_long,   1'b0);
        chk("areset_double", bus.o_double, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        pulse(17, 1'b0, 1'b1);
        goto(30);
        chk("areset_idle", bus.o_busy, 1'b0);

        // Stray release in IDLE, then simultaneous strobes during HELD
        do_reset();
        pulse(5, 1'b0, 1'b1);
        chk("stray_busy", bus.o_busy, 1'b0);
        pulse(10, 1'b1, 1'b0);
        pulse(12, 1'b1, 1'b1);
        chk("simul_held", bus.o_busy, 1'b1);
        goto(18);
        chk("simul_long", bus.o_long, 1'b1);
        pulse(20, 1'b0, 1'b1);
        goto(24);
        chk("simul_idle", bus.o_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
